hs_ram_port: RTL and testbench

Game-side responder for the high-score save/restore interface. It sits inside the game core between the CPU, the CPU work RAM and the `hiscore` module's RAM port (`hs_address`, `hs_data_in`, `hs_write`, `hs_access`, `hs_data_out`). On an access request it halts the CPU at a safe bus-cycle boundary, then hands the work-RAM port to the high-score engine with fixed read latency. When the request ends it returns the port to the CPU.

---
 rtl/hs_pkg.sv | 16 +
 rtl/hs_ram_port.sv | 111 +++++++++++
 tb/tb_hs_ram_port.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hs_pkg.sv
// Shared definitions for the high-score save/restore path: port FSM states
// and the default work-RAM geometry used by hiscore, hs_ram_port and the core top.
package hs_pkg;

    typedef enum logic [2:0] {
        HS_IDLE      = 3'd0,
        HS_WAIT_HALT = 3'd1,
        HS_SETTLE    = 3'd2,
        HS_GRANT     = 3'd3,
        HS_RELEASE   = 3'd4
    } hs_port_state_t;

    localparam int HS_AW = 12;
    localparam int HS_DW = 8;

endpackage

// File: rtl/hs_ram_port.sv
// Game-side responder for the high-score RAM port: halts the CPU at a bus-cycle
// boundary, lends the work-RAM port to hiscore, then returns it to the CPU.
module hs_ram_port
    import hs_pkg::*;
#(
    parameter int AW           = HS_AW,
    parameter int DW           = HS_DW,
    parameter int HALT_TIMEOUT = 64
) (
    input  logic           clk,
    input  logic           reset,
    // hiscore side: hs_access is a level held for the whole transfer; hs_ready
    // is high only while the port is granted. Reads return on hs_data_out two
    // cycles after hs_address, writes commit on the edge ending the hs_write cycle.
    input  logic           hs_access,
    input  logic [AW-1:0]  hs_address,
    input  logic [DW-1:0]  hs_data_in,
    input  logic           hs_write,
    output logic [DW-1:0]  hs_data_out,
    output logic           hs_ready,
    input  logic [AW-1:0]  cpu_addr,
    input  logic [DW-1:0]  cpu_din,
    input  logic           cpu_we,
    input  logic           cpu_cycle_end,
    output logic           cpu_halt,
    output logic [AW-1:0]  ram_addr,
    output logic [DW-1:0]  ram_din,
    output logic           ram_we,
    input  logic [DW-1:0]  ram_dout,
    output hs_port_state_t dbg_state
);

    localparam int CW = (HALT_TIMEOUT > 1) ? $clog2(HALT_TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(HALT_TIMEOUT - 1);

    hs_port_state_t state, state_nxt;
    logic [CW-1:0]  halt_cnt;
    logic           hs_side;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= HS_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Counter idles at zero so it is already cleared on entry to WAIT_HALT; saturates.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            halt_cnt <= '0;
        end else if (state == HS_IDLE) begin
            halt_cnt <= '0;
        end else if (state == HS_WAIT_HALT && halt_cnt != CNT_LAST) begin
            halt_cnt <= halt_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hs_data_out <= '0;
        end else if (state == HS_GRANT) begin
            hs_data_out <= ram_dout;
        end
    end

    always_comb begin
        state_nxt = state;
        hs_ready  = 1'b0;
        cpu_halt  = 1'b1;
        hs_side   = 1'b0;
        ram_we    = 1'b0;
        case (state)
            HS_IDLE: begin
                cpu_halt = 1'b0;
                ram_we   = cpu_we;
                if (hs_access) state_nxt = HS_WAIT_HALT;
            end
            HS_WAIT_HALT: begin
                ram_we = cpu_we;
                if (!hs_access) begin
                    state_nxt = HS_IDLE;
                end else if (cpu_cycle_end || halt_cnt == CNT_LAST) begin
                    state_nxt = HS_SETTLE;
                end
            end
            HS_SETTLE: begin
                hs_side   = 1'b1;
                state_nxt = HS_GRANT;
            end
            HS_GRANT: begin
                hs_side  = 1'b1;
                hs_ready = 1'b1;
                ram_we   = hs_write;
                if (!hs_access) state_nxt = HS_RELEASE;
            end
            HS_RELEASE: begin
                state_nxt = HS_IDLE;
            end
            default: begin
                cpu_halt  = 1'b0;
                state_nxt = HS_IDLE;
            end
        endcase
    end

    assign ram_addr  = hs_side ? hs_address : cpu_addr;
    assign ram_din   = hs_side ? hs_data_in : cpu_din;
    assign dbg_state = state;

endmodule

// File: tb/tb_hs_ram_port.sv
// Bench for hs_ram_port: a synchronous work RAM beside the DUT, a table of
// CPU-side mux vectors, hand sequences for the handshake timing, random GRANT traffic.
module tb_hs_ram_port;
    import hs_pkg::*;

    localparam int AW = 12;
    localparam int DW = 8;
    localparam int HALT_TIMEOUT = 64;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           hs_access = 1'b0;
    logic [AW-1:0]  hs_address = '0;
    logic [DW-1:0]  hs_data_in = '0;
    logic           hs_write = 1'b0;
    logic [DW-1:0]  hs_data_out;
    logic           hs_ready;
    logic [AW-1:0]  cpu_addr = '0;
    logic [DW-1:0]  cpu_din = '0;
    logic           cpu_we = 1'b0;
    logic           cpu_cycle_end = 1'b0;
    logic           cpu_halt;
    logic [AW-1:0]  ram_addr;
    logic [DW-1:0]  ram_din;
    logic           ram_we;
    logic [DW-1:0]  ram_dout = '0;
    hs_port_state_t dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] mem     [0:(1<<AW)-1] = '{default: 8'h00};
    logic [DW-1:0] ref_mem [0:(1<<AW)-1] = '{default: 8'h00};

    logic [DW-1:0] exp_q[$];
    bit            chk_q[$];

    hs_ram_port #(.AW(AW), .DW(DW), .HALT_TIMEOUT(HALT_TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .hs_access(hs_access), .hs_address(hs_address), .hs_data_in(hs_data_in),
        .hs_write(hs_write), .hs_data_out(hs_data_out), .hs_ready(hs_ready),
        .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_we(cpu_we),
        .cpu_cycle_end(cpu_cycle_end), .cpu_halt(cpu_halt),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
        .ram_dout(ram_dout), .dbg_state(dbg_state)
    );

    // ---------------- clock / work RAM ----------------
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        #3;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Called at mid-cycle; advances until hs_ready or the budget is used up.
    task automatic wait_ready(input int max_cycles, output int waited);
        waited = 0;
        while (!hs_ready && waited < max_cycles) begin
            cyc();
            mid();
            waited++;
        end
    endtask

    typedef struct {
        logic [AW-1:0] c_addr;
        logic [DW-1:0] c_din;
        logic          c_we;
        logic          h_write;
        logic [AW-1:0] h_addr;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_din;
        logic          e_we;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int waited;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          is_wr;

        // CPU owns the RAM in IDLE: hs inputs must never leak through.
        tbl[0] = '{12'h300, 8'h11, 1'b1, 1'b0, 12'h001, 12'h300, 8'h11, 1'b1};
        tbl[1] = '{12'h301, 8'h22, 1'b0, 1'b1, 12'h002, 12'h301, 8'h22, 1'b0};
        tbl[2] = '{12'hFFF, 8'hFF, 1'b1, 1'b1, 12'h000, 12'hFFF, 8'hFF, 1'b1};
        tbl[3] = '{12'h000, 8'h00, 1'b0, 1'b0, 12'hFFF, 12'h000, 8'h00, 1'b0};
        tbl[4] = '{12'h302, 8'hA5, 1'b1, 1'b0, 12'h555, 12'h302, 8'hA5, 1'b1};
        tbl[5] = '{12'h0AA, 8'h5A, 1'b0, 1'b1, 12'hAAA, 12'h0AA, 8'h5A, 1'b0};

        // ---------------- reset ----------------
        cyc(); cyc();
        mid();
        chk("rst_cpu_halt", cpu_halt, 0);
        chk("rst_hs_ready", hs_ready, 0);
        chk("rst_hs_data_out", hs_data_out, 0);
        chk("rst_state", dbg_state, HS_IDLE);
        reset = 1'b0;

        // ---------------- CPU write 0x5A -> 0x123 ----------------
        cyc();
        cpu_addr = 12'h123; cpu_din = 8'h5A; cpu_we = 1'b1;
        mid();
        chk("cpu_wr_we", ram_we, 1);
        chk("cpu_wr_addr", ram_addr, 12'h123);
        chk("cpu_wr_din", ram_din, 8'h5A);
        chk("cpu_wr_halt", cpu_halt, 0);
        chk("cpu_wr_ready", hs_ready, 0);
        ref_mem[12'h123] = 8'h5A;
        cyc();
        cpu_we = 1'b0;

        // ---------------- IDLE mux table ----------------
        for (int i = 0; i < 6; i++) begin
            cyc();
            cpu_addr = tbl[i].c_addr; cpu_din = tbl[i].c_din; cpu_we = tbl[i].c_we;
            hs_write = tbl[i].h_write; hs_address = tbl[i].h_addr;
            mid();
            chk($sformatf("tbl%0d_addr", i), ram_addr, tbl[i].e_addr);
            chk($sformatf("tbl%0d_din", i), ram_din, tbl[i].e_din);
            chk($sformatf("tbl%0d_we", i), ram_we, tbl[i].e_we);
            if (tbl[i].e_we) ref_mem[tbl[i].e_addr] = tbl[i].e_din;
        end
        cyc();
        cpu_we = 1'b0; hs_write = 1'b0;

        // ---------------- request with boundary strobe (N=10, B=14) ----------------
        hs_access = 1'b1;                        // N
        mid();
        chk("req_halt_N", cpu_halt, 0);
        cyc(); mid();                            // N+1
        chk("req_halt_N1", cpu_halt, 1);
        chk("req_ready_N1", hs_ready, 0);
        cyc(); cyc(); cyc();                     // N+4
        cpu_cycle_end = 1'b1;
        mid();
        chk("req_ready_B", hs_ready, 0);
        cyc();                                   // N+5
        cpu_cycle_end = 1'b0;
        cpu_we = 1'b1; cpu_addr = 12'h123; cpu_din = 8'hFF;
        mid();
        chk("settle_we", ram_we, 0);
        chk("settle_ready", hs_ready, 0);
        chk("settle_halt", cpu_halt, 1);
        cyc(); mid();                            // N+6 = B+2
        chk("grant_ready", hs_ready, 1);
        chk("grant_cpu_we_blocked", ram_we, 0);
        cpu_we = 1'b0;

        // ---------------- GRANT reads, fixed latency 2 ----------------
        cyc();                                   // K
        hs_address = 12'h123;
        cyc();                                   // K+1
        hs_address = 12'h124;
        cyc(); mid();                            // K+2
        chk("rd_123", hs_data_out, 8'h5A);
        cyc(); mid();                            // K+3
        chk("rd_124", hs_data_out, 8'h00);

        // ---------------- hs write then random GRANT traffic ----------------
        cyc();
        hs_address = 12'h010; hs_data_in = 8'hC3; hs_write = 1'b1;
        mid();
        chk("hs_wr_we", ram_we, 1);
        chk("hs_wr_addr", ram_addr, 12'h010);
        ref_mem[12'h010] = 8'hC3;
        exp_q.delete(); chk_q.delete();
        for (int c = 0; c < 44; c++) begin
            cyc();
            if (c < 40) begin
                a = AW'($urandom_range(0, 15));
                d = DW'($urandom_range(0, 255));
                is_wr = ($urandom_range(0, 2) == 0);
            end else begin
                a = '0; d = '0; is_wr = 1'b0;
            end
            hs_address = a; hs_data_in = d; hs_write = is_wr;
            exp_q.push_back(ref_mem[a]);
            chk_q.push_back(!is_wr && c < 40);
            if (is_wr) ref_mem[a] = d;
            mid();
            if (is_wr) chk("rand_wr_we", ram_we, 1);
            if (exp_q.size() == 3) begin
                if (chk_q.pop_front()) chk("rand_rd", hs_data_out, exp_q.pop_front());
                else void'(exp_q.pop_front());
            end
        end
        hs_write = 1'b0;

        // ---------------- release (M) ----------------
        cyc();
        hs_access = 1'b0;
        mid();
        chk("rel_ready_M", hs_ready, 1);
        cyc();                                   // M+1
        hs_write = 1'b1;
        mid();
        chk("rel_ready_M1", hs_ready, 0);
        chk("rel_halt_M1", cpu_halt, 1);
        chk("rel_we_blocked", ram_we, 0);
        cyc();                                   // M+2
        hs_write = 1'b0;
        mid();
        chk("rel_halt_M2", cpu_halt, 0);

        // CPU reads back what hiscore wrote
        cpu_addr = 12'h010;
        cyc(); mid();
        chk("cpu_rb_010", ram_dout, ref_mem[12'h010]);
        cpu_addr = 12'h300;
        cyc(); mid();
        chk("cpu_rb_300", ram_dout, ref_mem[12'h300]);

        // ---------------- timeout with no boundary strobe ----------------
        cyc();
        hs_access = 1'b1;                        // N
        cyc(); mid();                            // N+1
        chk("to_halt", cpu_halt, 1);
        wait_ready(200, waited);
        chk("to_latency", waited, HALT_TIMEOUT + 1);
        cyc();
        hs_access = 1'b0;
        cyc(); cyc(); mid();
        chk("to_rel_halt", cpu_halt, 0);

        // ---------------- abort during WAIT_HALT ----------------
        cyc();
        hs_access = 1'b1;                        // N
        cyc();                                   // N+1, WAIT_HALT
        hs_write = 1'b1; hs_address = 12'h020; hs_data_in = 8'h99;
        mid();
        chk("abort_wait_halt", cpu_halt, 1);
        chk("abort_wait_we", ram_we, 0);
        cyc();                                   // N+2
        hs_access = 1'b0;
        mid();
        chk("abort_still_wait", dbg_state, HS_WAIT_HALT);
        cyc(); mid();                            // N+3
        chk("abort_halt_drop", cpu_halt, 0);
        chk("abort_state", dbg_state, HS_IDLE);
        chk("abort_ready", hs_ready, 0);
        chk("abort_we", ram_we, 0);
        hs_write = 1'b0;
        cpu_addr = 12'h020;
        cyc(); mid();
        chk("abort_no_write", ram_dout, ref_mem[12'h020]);

        // ---------------- asynchronous reset mid-GRANT ----------------
        cyc();
        hs_access = 1'b1; cpu_cycle_end = 1'b1;
        mid();
        wait_ready(10, waited);
        chk("rst2_grant_reached", hs_ready, 1);
        cpu_cycle_end = 1'b0;
        cyc();
        hs_address = 12'h050; hs_data_in = 8'hEE; hs_write = 1'b1;
        cpu_addr = 12'h200;
        #1 reset = 1'b1;
        #1;
        chk("rst2_halt", cpu_halt, 0);
        chk("rst2_ready", hs_ready, 0);
        chk("rst2_dout", hs_data_out, 0);
        chk("rst2_we", ram_we, 0);
        chk("rst2_addr", ram_addr, 12'h200);
        hs_access = 1'b0; hs_write = 1'b0;
        #2 reset = 1'b0;
        cyc();
        cpu_addr = 12'h200; cpu_din = 8'h77; cpu_we = 1'b1;
        mid();
        chk("rst2_cpu_we", ram_we, 1);
        ref_mem[12'h200] = 8'h77;
        cyc();
        cpu_we = 1'b0;
        cyc(); mid();
        chk("rst2_cpu_rb", ram_dout, ref_mem[12'h200]);
        cpu_addr = 12'h050;
        cyc(); mid();
        chk("rst2_no_partial", ram_dout, ref_mem[12'h050]);

        // ---------------- report ----------------
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
